// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate L1 data cache controller (optional DCACHE_STATS_EN hit/miss counters)

module dcache_ctrl #(
  parameter int NUM_LINES = 32,
  parameter int TAG_W     = 32 - 5 - $clog2(NUM_LINES)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state_q;

  logic [255:0]         data_arr [NUM_LINES];
  logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  // Miss line captured at the IDLE->miss decision so the fill lands in the
  // right place even if the CPU withdraws its request mid-miss.
  logic [TAG_W-1:0]     miss_tag_q;
  logic [IDX_W-1:0]     miss_idx_q;

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic [2:0]           req_word;
  logic [255:0]         line_rd;
  logic                 hit;
  logic                 in_idle;
  logic                 ack;
  logic                 store_we;
  logic                 fill_we;
  logic                 unused_byte_sel;

  assign req_tag         = cpu_addr_i[31 -: TAG_W];
  assign req_idx         = cpu_addr_i[5 +: IDX_W];
  assign req_word        = cpu_addr_i[4:2];
  assign unused_byte_sel = ^cpu_addr_i[1:0];

  assign line_rd  = data_arr[req_idx];
  assign hit      = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
  assign in_idle  = (state_q == IDLE);
  // An ack is only meaningful while a request is actually outstanding.
  assign ack      = mem_ack_i && mem_req_o;
  assign store_we = in_idle && cpu_req_i && cpu_we_i && hit && !rst_i;
  assign fill_we  = (state_q == ALLOCATE) && ack && !rst_i;

  assign cpu_stall_o = in_idle ? (cpu_req_i && !hit) : 1'b1;
  assign cpu_data_o  = (in_idle && cpu_req_i && !cpu_we_i && hit)
                       ? line_rd[{req_word, 5'b0} +: 32] : 32'h0;

  // Data/tag storage: block fill from memory, or word merge on a store hit.
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      data_arr[miss_idx_q] <= mem_data_i;
      tag_arr[miss_idx_q]  <= miss_tag_q;
    end else if (store_we) begin
      data_arr[req_idx][{req_word, 5'b0} +: 32] <= cpu_data_i;
    end
  end

  // Miss-handling FSM with registered memory-side request outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req_i && hit && cpu_we_i) begin
            dirty_q[req_idx] <= 1'b1;
          end else if (cpu_req_i && !hit) begin
            miss_tag_q <= req_tag;
            miss_idx_q <= req_idx;
            mem_req_o  <= 1'b1;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_q    <= WRITEBACK;
              mem_we_o   <= 1'b1;
              mem_addr_o <= {tag_arr[req_idx], req_idx, 5'b0};
              mem_data_o <= line_rd;
            end else begin
              state_q    <= ALLOCATE;
              mem_we_o   <= 1'b0;
              mem_addr_o <= {req_tag, req_idx, 5'b0};
            end
          end
        end
        WRITEBACK: begin
          // Request drops for one cycle between the write-back and the fetch.
          if (ack) begin
            state_q    <= ALLOCATE;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= {miss_tag_q, miss_idx_q, 5'b0};
          end
        end
        ALLOCATE: begin
          if (ack) begin
            state_q             <= IDLE;
            mem_req_o           <= 1'b0;
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
          end else begin
            mem_req_o <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic prev_stall_q;

  // Count first-cycle hits (not the completing cycle of a miss) and miss launches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o    <= 32'h0;
      miss_cnt_o   <= 32'h0;
      prev_stall_q <= 1'b0;
    end else begin
      prev_stall_q <= cpu_stall_o;
      if (in_idle && cpu_req_i && hit && !prev_stall_q) begin
        hit_cnt_o <= hit_cnt_o + 32'h1;
      end
      if (in_idle && cpu_req_i && !hit) begin
        miss_cnt_o <= miss_cnt_o + 32'h1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl with a latency-programmable block memory model

module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
`ifdef DCACHE_STATS_EN
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt),
`endif
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
  } cpu_exp_t;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_exp_t;

  cpu_exp_t    cpu_q[$];
  mem_exp_t    mem_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          lat_rd   = 4;
  int          lat_wb   = 4;
  logic [31:0] store_mem [logic [31:0]];

  function automatic logic [255:0] pat_block(input logic [31:0] base);
    logic [255:0] b;
    for (int w = 0; w < 8; w++) b[w*32 +: 32] = (base + 32'(w * 4)) ^ 32'hA5A5_0000;
    return b;
  endfunction

  function automatic logic [255:0] mem_block(input logic [31:0] base);
    logic [255:0] b;
    b = pat_block(base);
    for (int w = 0; w < 8; w++)
      if (store_mem.exists(base + 32'(w * 4))) b[w*32 +: 32] = store_mem[base + 32'(w * 4)];
    return b;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [255:0] data);
    mem_exp_t e;
    e.we = we; e.addr = addr; e.data = data;
    mem_q.push_back(e);
  endtask

  // Issue one CPU access at posedge+1 and hold it until the DUT stops stalling.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input int exp_stall);
    cpu_exp_t e;
    int n;
    e.we = we; e.addr = addr; e.data = exp_data; e.stall = exp_stall;
    cpu_q.push_back(e);
    cpu_req_i  = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_data_i = wdata;
    n = 0;
    @(negedge clk);
    while (cpu_stall_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (cpu_stall_o) begin
      checks++;
      failures++;
      $display("FAIL access_timeout addr=%0h still stalled, required release", addr);
    end
    @(posedge clk);
    #1;
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
  endtask

  // Block memory: ack arrives once the request has been high for lat cycles.
  initial begin
    int cnt;
    cnt        = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        cnt       = 0;
      end else if (mem_req_o) begin
        if (cnt == (mem_we_o ? lat_wb : lat_rd)) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) begin
            for (int w = 0; w < 8; w++) store_mem[mem_addr_o + 32'(w * 4)] = mem_data_o[w*32 +: 32];
          end else begin
            mem_data_i = mem_block(mem_addr_o);
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // CPU-side monitor: one scoreboard entry per completed (unstalled) access.
  initial begin
    int stall_cnt;
    cpu_exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst_i || !cpu_req_i) begin
        stall_cnt = 0;
      end else if (cpu_stall_o) begin
        stall_cnt++;
      end else begin
        if (cpu_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cpu_unexpected addr=%0h completed, required no access", cpu_addr_i);
        end else begin
          e = cpu_q.pop_front();
          check($sformatf("cpu_stall@%0h", e.addr), 256'(stall_cnt), 256'(e.stall));
          if (!e.we) check($sformatf("cpu_rdata@%0h", e.addr), 256'(cpu_data_o), 256'(e.data));
        end
        stall_cnt = 0;
      end
    end
  end

  // Memory-side monitor: one scoreboard entry per acknowledged transaction.
  initial begin
    mem_exp_t e;
    forever begin
      @(negedge clk);
      if (mem_req_o && mem_ack_i) begin
        if (mem_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_unexpected we=%0b addr=%0h, required no transaction", mem_we_o, mem_addr_o);
        end else begin
          e = mem_q.pop_front();
          check($sformatf("mem_we@%0h", e.addr), 256'(mem_we_o), 256'(e.we));
          check($sformatf("mem_addr@%0h", e.addr), 256'(mem_addr_o), 256'(e.addr));
          if (e.we) check($sformatf("mem_wdata@%0h", e.addr), mem_data_o, e.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] blk;
    logic [31:0]  a;
    int           n;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit0;
    logic [31:0]  miss0;
`endif
    rst_i      = 1'b1;
    cpu_req_i  = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0;
    cpu_data_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_stall", 256'(cpu_stall_o), 256'(0));
    check("rst_mem_req", 256'(mem_req_o), 256'(0));
    check("rst_mem_we", 256'(mem_we_o), 256'(0));
    check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
    check("rst_cpu_data", 256'(cpu_data_o), 256'(0));
`ifdef DCACHE_STATS_EN
    check("rst_hit_cnt", 256'(hit_cnt), 256'(0));
    check("rst_miss_cnt", 256'(miss_cnt), 256'(0));
`endif
    @(posedge clk);
    #1;

    // Cold load miss, latency 4: stall 6, word 0 of the fill.
    lat_rd = 4;
    exp_mem(1'b0, 32'h0000_0100, '0);
    access(1'b0, 32'h0000_0100, 32'h0, 32'hA5A5_0100, 6);

    // Store hit then load hit of the stored word.
    access(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0);
    access(1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0);
    access(1'b0, 32'h0000_0108, 32'h0, 32'hA5A5_0108, 0);

    // Dirty eviction: write-back of 0x100 line, then fetch 0x500.
    lat_wb = 2;
    lat_rd = 5;
    blk = pat_block(32'h0000_0100);
    blk[63:32] = 32'hDEAD_BEEF;
    exp_mem(1'b1, 32'h0000_0100, blk);
    exp_mem(1'b0, 32'h0000_0500, '0);
    access(1'b0, 32'h0000_0504, 32'h0, 32'hA5A5_0504, 11);

    // Reload the evicted line: the written-back word comes back from memory.
    exp_mem(1'b0, 32'h0000_0100, '0);
    access(1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 7);

    // Reset in the middle of an allocate abandons the fill.
    lat_rd = 4;
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0900;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("abort_mem_req", 256'(mem_req_o), 256'(0));
    check("abort_stall", 256'(cpu_stall_o), 256'(0));
    exp_mem(1'b0, 32'h0000_0100, '0);
    access(1'b0, 32'h0000_0100, 32'h0, 32'hA5A5_0100, 6);
    access(1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 0);

    // Request withdrawn mid-allocate: fill still completes, no write-back.
    exp_mem(1'b0, 32'h0000_0200, '0);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0200;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    cpu_req_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (cpu_stall_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("withdrawn_fill_done", 256'(cpu_stall_o), 256'(0));
    @(posedge clk);
    #1;
    access(1'b0, 32'h0000_020C, 32'h0, 32'hA5A5_020C, 0);

    // Sweep every index with misses, then revisit each for zero-stall hits.
    lat_rd = 1;
`ifdef DCACHE_STATS_EN
    hit0  = hit_cnt;
    miss0 = miss_cnt;
`endif
    for (int i = 0; i < 32; i++) begin
      a = 32'h0000_1000 + 32'(i * 32) + 32'((i % 8) * 4);
      exp_mem(1'b0, {a[31:5], 5'b0}, '0);
      access(1'b0, a, 32'h0, a ^ 32'hA5A5_0000, 3);
    end
    for (int i = 0; i < 32; i++) begin
      a = 32'h0000_1000 + 32'(i * 32) + 32'((i % 8) * 4);
      access(1'b0, a, 32'h0, a ^ 32'hA5A5_0000, 0);
    end
`ifdef DCACHE_STATS_EN
    check("sweep_hit_cnt", 256'(hit_cnt - hit0), 256'(32));
    check("sweep_miss_cnt", 256'(miss_cnt - miss0), 256'(32));
`endif

    repeat (4) @(posedge clk);
    #1;
    check("cpu_queue_drained", 256'(cpu_q.size()), 256'(0));
    check("mem_queue_drained", 256'(mem_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
